// File: rtl/cpu_pkg.sv
// Shared CPU definitions: processor-status bit positions, flag_op encodings,
// and helpers to convert between the stored flags and the 8-bit P image.
package cpu_pkg;

  localparam int P_C = 0;
  localparam int P_Z = 1;
  localparam int P_I = 2;
  localparam int P_D = 3;
  localparam int P_B = 4;
  localparam int P_U = 5;
  localparam int P_V = 6;
  localparam int P_N = 7;

  typedef enum logic [2:0] {
    FOP_NONE = 3'b000,
    FOP_CLC  = 3'b001,
    FOP_SEC  = 3'b010,
    FOP_CLI  = 3'b011,
    FOP_SEI  = 3'b100,
    FOP_CLD  = 3'b101,
    FOP_SED  = 3'b110,
    FOP_CLV  = 3'b111
  } flag_op_e;

  typedef struct packed {
    logic n;
    logic v;
    logic d;
    logic i;
    logic z;
    logic c;
  } flags_t;

  localparam flags_t FLAGS_RESET = '{n: 1'b0, v: 1'b0, d: 1'b0, i: 1'b1, z: 1'b0, c: 1'b0};

  // B and the unused bit only exist in the pushed image, never in storage.
  function automatic flags_t unpack_p(input logic [7:0] p);
    flags_t f;
    f.n = p[P_N];
    f.v = p[P_V];
    f.d = p[P_D];
    f.i = p[P_I];
    f.z = p[P_Z];
    f.c = p[P_C];
    return f;
  endfunction

  function automatic logic [7:0] pack_p(input flags_t f, input logic brk);
    logic [7:0] p;
    p      = '0;
    p[P_N] = f.n;
    p[P_V] = f.v;
    p[P_U] = 1'b1;
    p[P_B] = brk;
    p[P_D] = f.d;
    p[P_I] = f.i;
    p[P_Z] = f.z;
    p[P_C] = f.c;
    return p;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an active-low asynchronous pin; resets to the
// idle (high) level.
module sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/status_flags.sv
// Processor status register: C/Z/I/D/V/N storage, SO/IRQ/NMI pin handling
// and the interrupt requests seen by the sequencer.
module status_flags
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       RDY,
  input  logic       CO,
  input  logic       V,
  input  logic       Z,
  input  logic       N,
  input  logic       upd_c,
  input  logic       upd_z,
  input  logic       upd_n,
  input  logic       upd_v,
  input  logic       bit_op,
  input  logic       load_p,
  input  logic [7:0] din,
  input  logic [2:0] flag_op,
  input  logic       sync,
  input  logic       brk,
  input  logic       so_n,
  input  logic       irq_n,
  input  logic       nmi_n,
  input  logic       nmi_ack,
  output logic [7:0] p_out,
  output logic       C_out,
  output logic       D_out,
  output logic       irq_take,
  output logic       nmi_take
);

  flags_t   f_q, f_d;
  flag_op_e fop;
  logic     i_eff_q;
  logic     so_sync, irq_sync, nmi_sync;
  logic     so_prev_q, nmi_prev_q;
  logic     so_pend_q, nmi_pend_q;
  logic     so_edge, nmi_edge, so_hit;
  logic [2:0] settle_q;
  logic     armed;

  sync2 u_sync_so  (.clk(clk), .reset_n(reset_n), .d(so_n),  .q(so_sync));
  sync2 u_sync_irq (.clk(clk), .reset_n(reset_n), .d(irq_n), .q(irq_sync));
  sync2 u_sync_nmi (.clk(clk), .reset_n(reset_n), .d(nmi_n), .q(nmi_sync));

  // The synchronizers reset high, so a pin held low through reset would look
  // like a falling edge; edges count only once prev holds a real pin sample.
  assign armed    = settle_q[2];
  assign so_edge  = armed & so_prev_q & ~so_sync;
  assign nmi_edge = armed & nmi_prev_q & ~nmi_sync;
  assign so_hit   = so_edge | so_pend_q;

  // Later assignments win: ALU/BIT < SO edge < flag_op < load_p.
  // NOTE: f_d starts as a copy of f_q so every path assigns it and no latch forms.
  always_comb begin
    f_d = f_q;
    fop = flag_op_e'(flag_op);
    if (bit_op) begin
      f_d.n = din[P_N];
      f_d.v = din[P_V];
    end else begin
      if (upd_n) f_d.n = N;
      if (upd_v) f_d.v = V;
    end
    if (upd_c) f_d.c = CO;
    if (upd_z) f_d.z = Z;
    if (so_hit) f_d.v = 1'b1;
    case (fop)
      FOP_CLC: f_d.c = 1'b0;
      FOP_SEC: f_d.c = 1'b1;
      FOP_CLI: f_d.i = 1'b0;
      FOP_SEI: f_d.i = 1'b1;
      FOP_CLD: f_d.d = 1'b0;
      FOP_SED: f_d.d = 1'b1;
      FOP_CLV: f_d.v = 1'b0;
      default: ;
    endcase
    if (load_p) f_d = unpack_p(din);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f_q        <= FLAGS_RESET;
      i_eff_q    <= 1'b1;
      so_prev_q  <= 1'b1;
      nmi_prev_q <= 1'b1;
      so_pend_q  <= 1'b0;
      nmi_pend_q <= 1'b0;
      settle_q   <= '0;
    end else begin
      settle_q   <= {settle_q[1:0], 1'b1};
      so_prev_q  <= so_sync;
      nmi_prev_q <= nmi_sync;
      if (nmi_edge)     nmi_pend_q <= 1'b1;
      else if (nmi_ack) nmi_pend_q <= 1'b0;
      if (RDY) begin
        f_q       <= f_d;
        so_pend_q <= 1'b0;
        if (sync) i_eff_q <= f_q.i;
      end else begin
        so_pend_q <= so_hit;
      end
    end
  end

  assign p_out    = pack_p(f_q, brk);
  assign C_out    = f_q.c;
  assign D_out    = f_q.d;
  assign irq_take = ~irq_sync & ~i_eff_q;
  assign nmi_take = nmi_pend_q;

endmodule

// File: doc/status_flags.md
STATUS_FLAGS -- requirements
Module: status_flags

Interface
REQ-001 SHALL have port clk  in  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port RDY  in  1  enable; when low, P and i_eff hold; synchronizers and NMI edge latch still run.
REQ-004 SHALL have ports CO, V, Z, N  in  1 each  registered flags from the ALU.
REQ-005 SHALL have ports upd_c, upd_z, upd_n, upd_v  in  1 each  per-flag ALU update enables from the decoder.
REQ-006 SHALL have port bit_op  in  1  BIT instruction: N<=din[7], V<=din[6], Z from ALU.
REQ-007 SHALL have ports load_p  in  1 and din  in  8  load P from the data bus (PLP/RTI).
REQ-008 SHALL have port flag_op  in  3  000 none, 001 CLC, 010 SEC, 011 CLI, 100 SEI, 101 CLD, 110 SED, 111 CLV.
REQ-009 SHALL have ports sync  in  1  opcode-fetch cycle marker, and brk  in  1  B value for the push image.
REQ-010 SHALL have ports so_n, irq_n, nmi_n  in  1 each  asynchronous pins, active low.
REQ-011 SHALL have port nmi_ack  in  1  clears the pending NMI.
REQ-012 SHALL have port p_out  out  8  push image {N,V,1,brk,D,I,Z,C}.
REQ-013 SHALL have ports C_out, D_out  out  1 each  carry and decimal mode for the ALU (CI, BCD).
REQ-014 SHALL have ports irq_take, nmi_take  out  1 each  interrupt requests to the sequencer.

Function
REQ-015 SHALL hold six flag registers: C, Z, I, D, V, N; bits 5 and 4 are not stored.
REQ-016 SHALL update flags only on a clock edge with RDY=1; priority load_p > flag_op > SO edge > ALU/BIT update.
REQ-017 SHALL, on load_p, set {N,V,D,I,Z,C} <= {din[7],din[6],din[3],din[2],din[1],din[0]}; din[5:4] ignored.
REQ-018 SHALL, on flag_op != 000, change only the addressed flag; other flags may still take ALU updates in the same cycle.
REQ-019 SHALL, per enabled flag, load C<=CO, Z<=Z, N<=N, V<=V; with bit_op=1, N<=din[7] and V<=din[6] regardless of upd_n/upd_v.
REQ-020 SHALL pass so_n through a 2-flop synchronizer and detect its falling edge; the edge sets V at the next RDY=1 edge, overriding an ALU V update, overridden by load_p or CLV.
REQ-021 SHALL hold a detected SO edge pending while RDY=0, and apply it once, at the first RDY=1 edge.
REQ-022 SHALL synchronize irq_n and nmi_n with 2 flops each; latency from pin to synced value is 2 cycles.
REQ-023 SHALL keep i_eff, a copy of I loaded at each edge with sync=1 and RDY=1; this gives the one-instruction CLI/SEI/PLP latency.
REQ-024 SHALL drive irq_take = ~irq_sync & ~i_eff, combinationally from registers.
REQ-025 SHALL set nmi_pend on a synced nmi_n falling edge; nmi_ack clears it; an edge in the same cycle as nmi_ack wins and keeps nmi_pend set.
REQ-026 SHALL drive nmi_take = nmi_pend.
REQ-027 SHALL drive C_out and D_out straight from the C and D registers, with no extra latency.

Reset
REQ-028 SHALL, while reset_n=0, force C=Z=V=N=D=0, I=1, i_eff=1, and nmi_pend=0.
REQ-029 SHALL, while reset_n=0, force all synchronizer flops to 1 (pins idle) and clear the SO pending flag.
REQ-030 SHALL, at reset, present p_out=8'h34 with brk=1 and 8'h24 with brk=0, and irq_take=nmi_take=0.
REQ-031 SHALL come out of reset mid-instruction with no spurious SO or NMI edge when the pins are held low through reset release.

Structure
REQ-032 SHALL take the flag bit positions (C=0 ... N=7) and the flag_op encodings from the shared package cpu_pkg.
REQ-033 SHALL build all three pin synchronizers (so_n, irq_n, nmi_n) from one reusable sub-module, sync2 (2-flop, reset to 1).

Verification
REQ-034 SHALL cover: upd_c=upd_z=upd_n=upd_v=1, CO=1, Z=1, N=0, V=1 -> p_out=8'hE3 is not produced; expected p_out=8'h67 (V,1,brk=0,I,Z,C).
REQ-035 SHALL cover: load_p with din=8'hFF and flag_op=001 in the same cycle -> p_out=8'hEF (brk=0), C=1.
REQ-036 SHALL cover: CLI executed, irq_n low throughout -> irq_take stays 0 until the next sync edge, then goes 1.
REQ-037 SHALL cover: nmi_n falls, and nmi_ack pulses 3 cycles later while a second falling edge arrives -> nmi_take stays 1.
REQ-038 SHALL cover: so_n falls while RDY=0 -> V=0 until RDY rises, then V=1 at that edge, applied once.
REQ-039 SHALL cover: BIT with din=8'hC0, upd_n=upd_v=0, ALU Z=1 and upd_z=1 -> N=1, V=1, Z=1.
